// File: rtl/uart_word_loader_pkg.sv
// Shared types for the UART word loader: FSM state encoding and byte width.
// Latency: none (types and constants only).
// Backpressure: none; the loader has no stall path toward uart_receiver.
package uart_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } loader_state_t;

endpackage

// File: rtl/uart_word_loader_byte_packer.sv
// byte_packer: tracks the byte index and inserts bytes into the word under assembly.
// Latency: word output is combinational and already includes the byte currently on byte_data.
// Backpressure: none; accepts a byte every cycle that accept is high.
module byte_packer
  import uart_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter bit BIG_ENDIAN     = 1'b0,
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1,
  localparam int DATA_W = BYTE_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_data,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] word,
  output logic              last_byte
);

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d, word_ins;
  int                lane;

  // Insert the incoming byte into its lane; lane order depends on endianness.
  // The insert does not depend on accept so the caller can use it in the same cycle.
  always_comb begin
    lane     = BIG_ENDIAN ? (BYTES_PER_WORD - 1 - int'(idx_q)) : int'(idx_q);
    word_ins = word_q;
    word_ins[lane*BYTE_W +: BYTE_W] = byte_data;
  end

  // Index advance and word capture; clear abandons a partial word.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (accept) begin
      word_d = word_ins;
      idx_d  = last_byte ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Byte index and shift register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign last_byte = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign idx       = idx_q;
  assign word      = word_ins;

endmodule

// File: rtl/uart_word_loader.sv
// uart_word_loader: packs uart_receiver bytes into words and writes them sequentially to instr_mem.
// Latency: mem_we one cycle after the last byte strobe of a word; done one cycle after the final write.
// Backpressure: none; bytes outside a session are dropped and flagged in err_ovf.
// Optional partial-word timeout is compiled in with `define LOADER_TIMEOUT_EN.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 8,
  parameter bit BIG_ENDIAN     = 1'b0,
  parameter int TIMEOUT_CYC    = 100000,
  localparam int DATA_W = BYTE_W * BYTES_PER_WORD,
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_ovf,
  output logic [ADDR_W:0]   words_wr
);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   num_q, num_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              pk_clear, pk_accept, pk_last;
  logic [IDX_W-1:0]  pk_idx;
  logic [DATA_W-1:0] pk_word;

  byte_packer #(
    .BYTES_PER_WORD (BYTES_PER_WORD),
    .BIG_ENDIAN     (BIG_ENDIAN)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .accept    (pk_accept),
    .byte_data (byte_data),
    .idx       (pk_idx),
    .word      (pk_word),
    .last_byte (pk_last)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_hit;

  // Idle counter for a partially filled word; any byte or leaving COLLECT clears it.
  always_comb begin
    to_cnt_d = '0;
    to_hit   = 1'b0;
    if (!start && !byte_valid && state_q == COLLECT && pk_idx != '0) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) to_hit = 1'b1;
      else                                    to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  // Timeout counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_to;
  assign unused_to = (TIMEOUT_CYC == 0) | (|pk_idx);
`endif

  // Session FSM: start arms/aborts, bytes fill words, full words become one-cycle writes.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    num_d       = num_q;
    words_d     = words_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    pk_clear    = 1'b0;
    pk_accept   = 1'b0;
    if (start) begin
      addr_d   = base_addr;
      num_d    = num_words;
      words_d  = '0;
      err_d    = 1'b0;
      pk_clear = 1'b1;
      if (num_words == '0) begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = COLLECT;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        COLLECT, WRITE: begin
          if (state_q == WRITE && words_q == num_q) begin
            // Final word just went out; no session left to take a byte.
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            if (byte_valid) err_d = 1'b1;
          end else begin
            state_d = COLLECT;
            if (byte_valid) begin
              pk_accept = 1'b1;
              if (pk_last) begin
                state_d     = WRITE;
                mem_we_d    = 1'b1;
                mem_addr_d  = addr_q;
                mem_wdata_d = pk_word;
                addr_d      = addr_q + ADDR_W'(1);
                words_d     = words_q + (ADDR_W+1)'(1);
              end
            end
`ifdef LOADER_TIMEOUT_EN
            if (to_hit) pk_clear = 1'b1;
`endif
          end
        end
        default: begin
          // IDLE and DONE both settle in IDLE and reject stray bytes.
          state_d = IDLE;
          busy_d  = 1'b0;
          if (byte_valid) err_d = 1'b1;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      num_q       <= '0;
      words_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      num_q       <= num_d;
      words_q     <= words_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err_ovf   = err_q;
  assign words_wr  = words_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Bench: little- and big-endian loaders share one byte stream; writes are checked against a queue.
// Timeout behaviour follows LOADER_TIMEOUT_EN as compiled.
module tb_uart_word_loader;

  localparam int BPW = 4;
  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int TO  = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;

  logic          le_we, le_busy, le_done, le_err;
  logic [AW-1:0] le_addr;
  logic [DW-1:0] le_wdata;
  logic [AW:0]   le_words;
  logic          be_we, be_busy, be_done, be_err;
  logic [AW-1:0] be_addr;
  logic [DW-1:0] be_wdata;
  logic [AW:0]   be_words;

  uart_word_loader #(.BYTES_PER_WORD(BPW), .ADDR_W(AW), .BIG_ENDIAN(1'b0), .TIMEOUT_CYC(TO)) dut_le (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .mem_we(le_we), .mem_addr(le_addr),
    .mem_wdata(le_wdata), .busy(le_busy), .done(le_done), .err_ovf(le_err), .words_wr(le_words));

  uart_word_loader #(.BYTES_PER_WORD(BPW), .ADDR_W(AW), .BIG_ENDIAN(1'b1), .TIMEOUT_CYC(TO)) dut_be (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .mem_we(be_we), .mem_addr(be_addr),
    .mem_wdata(be_wdata), .busy(be_busy), .done(be_done), .err_ovf(be_err), .words_wr(be_words));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q_le[$];
  exp_t          q_be[$];
  logic [AW-1:0] m_addr = '0;
  int            vectors = 0;
  int            miscompares = 0;
  int            done_le = 0;
  int            done_be = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (le_we === 1'b1) begin
      if (q_le.size() == 0) check("le_unexpected_we", le_we, 1'b0);
      else begin
        e = q_le.pop_front();
        check("le_addr", le_addr, e.addr);
        check("le_wdata", le_wdata, e.data);
      end
    end
    if (be_we === 1'b1) begin
      if (q_be.size() == 0) check("be_unexpected_we", be_we, 1'b0);
      else begin
        e = q_be.pop_front();
        check("be_addr", be_addr, e.addr);
        check("be_wdata", be_wdata, e.data);
      end
    end
    if (le_done === 1'b1) done_le++;
    if (be_done === 1'b1) done_be++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    start = 1'b1; base_addr = b; num_words = n; m_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    byte_valid = 1'b1; byte_data = b;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b0, b1, b2, b3);
    exp_t e;
    e.addr = m_addr; e.data = {b3, b2, b1, b0}; q_le.push_back(e);
    e.data = {b0, b1, b2, b3};                  q_be.push_back(e);
    m_addr = m_addr + 8'd1;
  endtask

  // Sends one full word with a gap after it and checks the one-cycle write latency.
  task automatic send_word(input logic [7:0] b0, b1, b2, b3);
    push_exp(b0, b1, b2, b3);
    drive_byte(b0); drive_byte(b1); drive_byte(b2); drive_byte(b3);
    @(negedge clk);
    check("le_we_latency", le_we, 1'b1);
    check("be_we_latency", be_we, 1'b1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"}, le_we, 0);       check({tag, "_addr"}, le_addr, 0);
    check({tag, "_wdata"}, le_wdata, 0); check({tag, "_busy"}, le_busy, 0);
    check({tag, "_done"}, le_done, 0);   check({tag, "_err"}, le_err, 0);
    check({tag, "_words"}, le_words, 0);
    check({tag, "_be_we"}, be_we, 0);    check({tag, "_be_wdata"}, be_wdata, 0);
    check({tag, "_be_busy"}, be_busy, 0);
  endtask

  initial begin
    int d0;
    logic [7:0] a;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Little-endian two-word session, done one cycle after the second write
    do_start(8'h10, 9'd2);
    check("t1_busy", le_busy, 1'b1);
    send_word(8'h13, 8'h00, 8'h00, 8'h93);
    send_word(8'h11, 8'h22, 8'h33, 8'h44);
    check("t1_done", le_done, 1'b1);
    check("t1_words", le_words, 9'd2);
    check("t1_busy_end", le_busy, 1'b0);
    tick();
    check("t1_done_pulse", le_done, 1'b0);
    check("t1_done_cnt", done_le, 1);

    // Big-endian packing on the second instance
    do_start(8'h20, 9'd1);
    send_word(8'h00, 8'h00, 8'h00, 8'h13);
    tick(); tick();

    // Back-to-back bytes: one strobe every cycle across 8 words
    d0 = done_le;
    do_start(8'h30, 9'd8);
    for (int w = 0; w < 8; w++) begin
      a = 8'hA0 + 8'(4 * w);
      push_exp(a, a + 8'd1, a + 8'd2, a + 8'd3);
    end
    for (int i = 0; i < 32; i++) begin
      byte_valid = 1'b1; byte_data = 8'hA0 + 8'(i);
      tick();
    end
    byte_valid = 1'b0;
    tick(); tick(); tick();
    check("t3_words", le_words, 9'd8);
    check("t3_done_cnt", done_le, d0 + 1);
    check("t3_q_le_drained", q_le.size(), 0);
    check("t3_q_be_drained", q_be.size(), 0);

    // Address wrap at the top of the address space
    do_start(8'hFF, 9'd2);
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
    send_word(8'h05, 8'h06, 8'h07, 8'h08);
    tick();
    check("t4_addr_wrap", le_addr, 8'h00);

    // Stray bytes, start clearing err_ovf, restart dropping a partial word
    drive_byte(8'h55);
    check("t5_err_set", le_err, 1'b1);
    check("t5_be_err_set", be_err, 1'b1);
    do_start(8'h40, 9'd1);
    check("t5_err_clr", le_err, 1'b0);
    drive_byte(8'hEE); drive_byte(8'hEF);
    d0 = done_le;
    do_start(8'h50, 9'd1);
    check("t5_restart_no_done", le_done, 1'b0);
    send_word(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    tick();
    check("t5_done_cnt", done_le, d0 + 1);
    check("t5_words", le_words, 9'd1);

    // Zero-length session finishes immediately
    do_start(8'h60, 9'd0);
    check("t5_zero_done", le_done, 1'b1);
    check("t5_zero_busy", le_busy, 1'b0);
    tick();

    // Partial word followed by a long idle gap
    do_start(8'h70, 9'd1);
    drive_byte(8'hDE); drive_byte(8'hAD);
    repeat (TO) tick();
`ifdef LOADER_TIMEOUT_EN
    send_word(8'h01, 8'h02, 8'h03, 8'h04);
`else
    push_exp(8'hDE, 8'hAD, 8'h01, 8'h02);
    drive_byte(8'h01); drive_byte(8'h02);
    @(negedge clk);
    check("t6_we_latency", le_we, 1'b1);
    tick();
`endif
    check("t6_words", le_words, 9'd1);
    tick();

    // Reset in the middle of a word
    do_start(8'h80, 9'd2);
    drive_byte(8'h12); drive_byte(8'h34);
    #2 rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    tick();
    rst = 1'b0;
    tick();
    do_start(8'h90, 9'd1);
    send_word(8'h9A, 8'h9B, 8'h9C, 8'h9D);
    tick(); tick();

    check("end_q_le_empty", q_le.size(), 0);
    check("end_q_be_empty", q_be.size(), 0);
    check("end_done_match", done_be, done_le);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
